// File: rtl/cv32e40p_tb_periph_pkg.sv
// Shared constants and enums for the testbench pseudo-peripheral.
package cv32e40p_tb_periph_pkg;

  localparam logic [31:0] DEF_PRINT_ADDR  = 32'h1000_0000;
  localparam logic [31:0] DEF_CYCLE_ADDR  = 32'h1500_0004;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h2000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'h2000_0004;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;

  localparam logic [31:0] PASS_VALUE = 32'd123456789;
  localparam logic [31:0] FAIL_VALUE = 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PULSE
  } periph_state_e;

  typedef enum logic [1:0] {
    PEND_PASS,
    PEND_FAIL,
    PEND_EXIT
  } pend_kind_e;

endpackage

// File: rtl/cv32e40p_tb_print_fifo.sv
// Console character FIFO; pointers carry an extra wrap bit to tell full from empty.
module cv32e40p_tb_print_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero when empty so the character output is clean out of reset.
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_tb_periph.sv
// Memory-mapped console/status peripheral; pass/fail/exit pulses are held back
// until every earlier console character has left the print FIFO.
module cv32e40p_tb_periph
  import cv32e40p_tb_periph_pkg::*;
#(
  parameter logic [31:0] PRINT_ADDR  = DEF_PRINT_ADDR,
  parameter logic [31:0] CYCLE_ADDR  = DEF_CYCLE_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        print_valid_o,
  output logic [31:0] print_wdata_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  periph_state_e state_q;
  pend_kind_e    kind_q;
  logic [31:0]   pend_value_q;
  logic [31:0]   cycle_cnt_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic [7:0] fifo_head;

  logic is_print;
  logic is_status;
  logic is_exit;
  logic is_cycle;
  logic word_wr;
  logic pass_hit;
  logic fail_hit;
  logic exit_hit;

  assign is_print  = (data_addr_i == PRINT_ADDR);
  assign is_status = (data_addr_i == STATUS_ADDR);
  assign is_exit   = (data_addr_i == EXIT_ADDR);
  assign is_cycle  = (data_addr_i == CYCLE_ADDR);
  assign word_wr   = data_we_i && (data_be_i == 4'hF);

  // Full is checked against the registered state only, so a same-cycle pop cannot sneak a push in.
  assign data_gnt_o = data_req_i && (state_q == ST_IDLE) && !(data_we_i && is_print && fifo_full);

  assign fifo_push = data_gnt_o && data_we_i && is_print && data_be_i[0];
  assign pass_hit  = data_gnt_o && word_wr && is_status && (data_wdata_i == PASS_VALUE);
  assign fail_hit  = data_gnt_o && word_wr && is_status && (data_wdata_i == FAIL_VALUE);
  assign exit_hit  = data_gnt_o && word_wr && is_exit;

  cv32e40p_tb_print_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_print_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .wdata  (data_wdata_i[7:0]),
    .pop    (!fifo_empty),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign print_valid_o = !fifo_empty;
  assign print_wdata_o = {24'b0, fifo_head};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q   <= '0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 32'd1;
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= (data_gnt_o && !data_we_i && is_cycle) ? cycle_cnt_q : 32'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      kind_q         <= PEND_PASS;
      pend_value_q   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pass_hit || fail_hit || exit_hit) begin
            kind_q  <= exit_hit ? PEND_EXIT : (pass_hit ? PEND_PASS : PEND_FAIL);
            state_q <= ST_DRAIN;
            if (exit_hit) pend_value_q <= data_wdata_i;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_PULSE;
            case (kind_q)
              PEND_PASS: tests_passed_o <= 1'b1;
              PEND_FAIL: tests_failed_o <= 1'b1;
              PEND_EXIT: begin
                exit_valid_o <= 1'b1;
                exit_value_o <= pend_value_q;
              end
              default: ;
            endcase
          end
        end
        ST_PULSE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_tb_periph.sv
// Directed, table-driven bench for cv32e40p_tb_periph.
module tb_cv32e40p_tb_periph;
  import cv32e40p_tb_periph_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        print_valid_o;
  logic [31:0] print_wdata_o;
  logic        tests_passed_o;
  logic        tests_failed_o;
  logic        exit_valid_o;
  logic [31:0] exit_value_o;

  cv32e40p_tb_periph dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .print_valid_o  (print_valid_o),
    .print_wdata_o  (print_wdata_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wd;
  endtask

  task automatic idle_bus();
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_addr_i  = '0;
    data_be_i    = '0;
    data_wdata_i = '0;
  endtask

  // Read CYCLE_ADDR: request at current negedge, result at the following negedge.
  task automatic read_cycle(input string name, output logic [31:0] val);
    drive(1'b0, DEF_CYCLE_ADDR, 4'hF, 32'h0);
    #1 check({name, " gnt"}, {31'b0, data_gnt_o}, 32'd1);
    @(negedge clk_i);
    idle_bus();
    check({name, " rvalid"}, {31'b0, data_rvalid_o}, 32'd1);
    val = data_rdata_o;
  endtask

  // pulse field: {passed, failed, exit}
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_print;
    logic [7:0]  exp_char;
    logic [2:0]  exp_pulse;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  logic [31:0] exit_model;
  logic [31:0] r0, r1;
  logic [7:0]  msg[9];
  logic [7:0]  ord_char[8];
  logic        ord_pv[8];
  logic        ord_gnt[8];
  logic        ord_pass[8];

  initial begin
    vecs[0]  = '{1'b1, DEF_PRINT_ADDR,  4'h1, 32'h0000_0041, 32'h0, 1'b1, 8'h41, 3'b000};
    vecs[1]  = '{1'b1, DEF_PRINT_ADDR,  4'h2, 32'h0000_4242, 32'h0, 1'b0, 8'h00, 3'b000};
    vecs[2]  = '{1'b1, DEF_PRINT_ADDR,  4'hF, 32'hFFFF_FF55, 32'h0, 1'b1, 8'h55, 3'b000};
    vecs[3]  = '{1'b1, DEF_STATUS_ADDR, 4'hF, 32'd123456789, 32'h0, 1'b0, 8'h00, 3'b100};
    vecs[4]  = '{1'b1, DEF_STATUS_ADDR, 4'hF, 32'd1,         32'h0, 1'b0, 8'h00, 3'b010};
    vecs[5]  = '{1'b1, DEF_STATUS_ADDR, 4'hF, 32'd5,         32'h0, 1'b0, 8'h00, 3'b000};
    vecs[6]  = '{1'b1, DEF_STATUS_ADDR, 4'h3, 32'd123456789, 32'h0, 1'b0, 8'h00, 3'b000};
    vecs[7]  = '{1'b1, DEF_EXIT_ADDR,   4'hF, 32'h0000_002A, 32'h0, 1'b0, 8'h00, 3'b001};
    vecs[8]  = '{1'b1, DEF_EXIT_ADDR,   4'h7, 32'h0000_0099, 32'h0, 1'b0, 8'h00, 3'b000};
    vecs[9]  = '{1'b1, 32'h3000_0000,   4'hF, 32'd123456789, 32'h0, 1'b0, 8'h00, 3'b000};
    vecs[10] = '{1'b0, DEF_PRINT_ADDR,  4'hF, 32'h0000_0043, 32'h0, 1'b0, 8'h00, 3'b000};
    msg = '{8'h48, 8'h69, 8'h2C, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
    exit_model = 32'h0;

    // Reset values
    #2;
    check("rst gnt", {31'b0, data_gnt_o}, 32'd0);
    check("rst flags", {27'b0, data_rvalid_o, print_valid_o, tests_passed_o, tests_failed_o,
                        exit_valid_o}, 32'd0);
    check("rst rdata", data_rdata_o, 32'd0);
    check("rst print_wdata", print_wdata_o, 32'd0);
    check("rst exit_value", exit_value_o, 32'd0);
    check("rst counter", dut.cycle_cnt_q, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single transactions from idle with an empty FIFO
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      #1 check($sformatf("v%0d gnt", i), {31'b0, data_gnt_o}, 32'd1);
      @(negedge clk_i);
      idle_bus();
      check($sformatf("v%0d rvalid", i), {31'b0, data_rvalid_o}, 32'd1);
      check($sformatf("v%0d rdata", i), data_rdata_o, vecs[i].exp_rdata);
      check($sformatf("v%0d print_valid", i), {31'b0, print_valid_o}, {31'b0, vecs[i].exp_print});
      if (vecs[i].exp_print)
        check($sformatf("v%0d print_wdata", i), print_wdata_o, {24'b0, vecs[i].exp_char});
      check($sformatf("v%0d early pulse", i),
            {29'b0, tests_passed_o, tests_failed_o, exit_valid_o}, 32'd0);
      @(negedge clk_i);
      if (vecs[i].exp_pulse[0]) exit_model = vecs[i].wdata;
      check($sformatf("v%0d pulse", i),
            {29'b0, tests_passed_o, tests_failed_o, exit_valid_o}, {29'b0, vecs[i].exp_pulse});
      check($sformatf("v%0d exit_value", i), exit_value_o, exit_model);
      check($sformatf("v%0d rvalid drop", i), {31'b0, data_rvalid_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      check($sformatf("v%0d quiet", i),
            {28'b0, print_valid_o, tests_passed_o, tests_failed_o, exit_valid_o}, 32'd0);
    end

    // Back-to-back burst of 9 characters, one per cycle, in order
    @(negedge clk_i);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, DEF_PRINT_ADDR, 4'h1, {24'b0, msg[i]});
      #1 check($sformatf("burst%0d gnt", i), {31'b0, data_gnt_o}, 32'd1);
      if (i > 0) begin
        check($sformatf("burst%0d pv", i), {31'b0, print_valid_o}, 32'd1);
        check($sformatf("burst%0d char", i), print_wdata_o, {24'b0, msg[i-1]});
      end
      @(negedge clk_i);
    end
    idle_bus();
    check("burst last pv", {31'b0, print_valid_o}, 32'd1);
    check("burst last char", print_wdata_o, {24'b0, msg[8]});
    @(negedge clk_i);
    check("burst drained", {31'b0, print_valid_o}, 32'd0);

    // Grant rule with a full FIFO: only PRINT writes are held off
    force dut.fifo_full = 1'b1;
    drive(1'b1, DEF_PRINT_ADDR, 4'h1, 32'h0000_0058);
    #1 check("full print gnt", {31'b0, data_gnt_o}, 32'd0);
    drive(1'b0, DEF_PRINT_ADDR, 4'hF, 32'h0);
    #1 check("full read gnt", {31'b0, data_gnt_o}, 32'd1);
    drive(1'b1, 32'h3000_0000, 4'hF, 32'h0);
    #1 check("full other wr gnt", {31'b0, data_gnt_o}, 32'd1);
    idle_bus();
    release dut.fifo_full;
    repeat (2) @(negedge clk_i);

    // Three characters, then PASS: pulse only after the last character drained
    ord_char = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h00, 8'h00, 8'h00, 8'h00};
    ord_pv   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ord_gnt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ord_pass = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int s = 0; s < 8; s++) begin
      if (s < 3)      drive(1'b1, DEF_PRINT_ADDR, 4'h1, {24'b0, 8'h61 + 8'(s)});
      else if (s == 3) drive(1'b1, DEF_STATUS_ADDR, 4'hF, PASS_VALUE);
      else if (s < 7)  drive(1'b0, DEF_STATUS_ADDR, 4'hF, 32'h0);
      else            idle_bus();
      #1;
      check($sformatf("ord%0d gnt", s), {31'b0, data_gnt_o}, {31'b0, ord_gnt[s]});
      check($sformatf("ord%0d pv", s), {31'b0, print_valid_o}, {31'b0, ord_pv[s]});
      if (ord_pv[s]) check($sformatf("ord%0d char", s), print_wdata_o, {24'b0, ord_char[s]});
      check($sformatf("ord%0d pass", s), {31'b0, tests_passed_o}, {31'b0, ord_pass[s]});
      @(negedge clk_i);
    end
    idle_bus();
    repeat (2) @(negedge clk_i);

    // Cycle counter: 10-cycle spacing, then wrap
    read_cycle("cyc a", r0);
    repeat (9) @(negedge clk_i);
    read_cycle("cyc b", r1);
    check("cyc delta", r1 - r0, 32'd10);
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_cnt_q;
    @(negedge clk_i);
    read_cycle("wrap a", r0);
    check("wrap max", r0, 32'hFFFF_FFFF);
    read_cycle("wrap b", r1);
    check("wrap zero", r1, 32'h0000_0000);
    repeat (2) @(negedge clk_i);

    // Reset while draining: everything clears and nothing pending survives
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DEF_PRINT_ADDR, 4'h1, {24'b0, 8'h77 + 8'(i)});
      @(negedge clk_i);
    end
    drive(1'b1, DEF_EXIT_ADDR, 4'hF, 32'h0000_0077);
    @(negedge clk_i);
    drive(1'b0, DEF_STATUS_ADDR, 4'hF, 32'h0);
    #1 check("drain blocks gnt", {31'b0, data_gnt_o}, 32'd0);
    idle_bus();
    rst_ni = 1'b0;
    #1;
    check("mid rst flags", {27'b0, data_rvalid_o, print_valid_o, tests_passed_o, tests_failed_o,
                            exit_valid_o}, 32'd0);
    check("mid rst print_wdata", print_wdata_o, 32'd0);
    check("mid rst exit_value", exit_value_o, 32'd0);
    check("mid rst counter", dut.cycle_cnt_q, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check($sformatf("post rst%0d", i), {27'b0, data_rvalid_o, print_valid_o, tests_passed_o,
                                          tests_failed_o, exit_valid_o}, 32'd0);
    end
    check("post rst exit_value", exit_value_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
